// File: rtl/csr_pkg.sv
// Shared definitions for the user-mode CSR/trap unit: CSR addresses, cause codes,
// CSR op encodings and ustatus bit positions.
package csr_pkg;

    localparam logic [11:0] CSR_USTATUS  = 12'h000;
    localparam logic [11:0] CSR_UIE      = 12'h004;
    localparam logic [11:0] CSR_UTVEC    = 12'h005;
    localparam logic [11:0] CSR_USCRATCH = 12'h040;
    localparam logic [11:0] CSR_UEPC     = 12'h041;
    localparam logic [11:0] CSR_UCAUSE   = 12'h042;
    localparam logic [11:0] CSR_UTVAL    = 12'h043;
    localparam logic [11:0] CSR_UIP      = 12'h044;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH = 12'hC82;

    localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] CAUSE_BREAK   = 32'd3;
    localparam logic [31:0] CAUSE_ECALL_U = 32'd8;

    localparam logic [3:0] IRQ_SOFT  = 4'd0;
    localparam logic [3:0] IRQ_TIMER = 4'd4;
    localparam logic [3:0] IRQ_EXT   = 4'd8;

    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    // funct3[1:0] selects the operation; funct3[2] only selects the source.
    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    localparam int USTATUS_UIE  = 0;
    localparam int USTATUS_UPIE = 4;

    localparam logic [31:0] UIE_MASK = 32'h0000_0111;

    function automatic logic [31:0] csr_modify(input csr_op_e op,
                                               input logic [31:0] old_val,
                                               input logic [31:0] src);
        case (op)
            CSR_OP_RW: csr_modify = src;
            CSR_OP_RS: csr_modify = old_val | src;
            CSR_OP_RC: csr_modify = old_val & ~src;
            default:   csr_modify = old_val;
        endcase
    endfunction

endpackage

// File: rtl/csr_counters.sv
// 64-bit cycle and instret counters with their read-only CSR read mux.
module csr_counters
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        instret_inc,
    input  logic [11:0] addr,
    output logic [31:0] rdata,
    output logic        hit
);

    logic [63:0] cycle_q;
    logic [63:0] instret_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q   <= 64'd0;
            instret_q <= 64'd0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
            if (instret_inc) begin
                instret_q <= instret_q + 64'd1;
            end
        end
    end

    // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
    always_comb begin
        rdata = 32'd0;
        hit   = 1'b1;
        case (addr)
            CSR_CYCLE:    rdata = cycle_q[31:0];
            CSR_INSTRET:  rdata = instret_q[31:0];
            CSR_CYCLEH:   rdata = cycle_q[63:32];
            CSR_INSTRETH: rdata = instret_q[63:32];
            default:      hit   = 1'b0;
        endcase
    end

endmodule

// File: rtl/csr_trap_unit.sv
// User-mode CSR file with read/modify/write, trap entry for exceptions and
// interrupts, uret return and the fetch redirect target.
module csr_trap_unit
    import csr_pkg::*;
#(
    parameter logic [31:0] RESET_UTVEC  = 32'h0000_0000,
    parameter bit          HAS_COUNTERS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        csr,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_data,
    input  logic        exception,
    input  logic [31:0] cause,
    input  logic        uret,
    input  logic        ext_irq,
    input  logic        timer_irq,
    output logic [31:0] csr_rdata,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        trap_taken
);

    logic        uie_bit_q;
    logic        upie_q;
    logic [31:0] uie_q;
    logic [31:0] utvec_q;
    logic [31:0] uscratch_q;
    logic [31:0] uepc_q;
    logic [31:0] ucause_q;
    logic [31:0] utval_q;
    logic        usip_q;

    logic [11:0] csr_addr;
    logic [4:0]  src_field;
    csr_op_e     op;
    logic [31:0] src;
    logic        write_attempt;
    logic        read_only;
    logic        mapped;
    logic [31:0] old_val;
    logic [31:0] new_val;
    logic [31:0] uip_val;
    logic [31:0] irq_vec;
    logic [3:0]  irq_code;
    logic        csr_illegal;
    logic        irq_take;
    logic        exc_take;
    logic        uret_take;
    logic        csr_we;
    logic [31:0] exc_cause;
    logic [31:0] vec_offset;
    logic [31:0] cnt_rdata;
    logic        cnt_hit;

    assign csr_addr  = instr[31:20];
    assign src_field = instr[19:15];
    assign op        = csr_op_e'(funct3[1:0]);
    assign src       = funct3[2] ? {27'd0, src_field} : rs1_data;

    // RS/RC with a zero source field are pure reads and never count as a write.
    assign write_attempt = (op == CSR_OP_RW) ||
                           (((op == CSR_OP_RS) || (op == CSR_OP_RC)) && (src_field != 5'd0));
    assign read_only     = (csr_addr[11:10] == 2'b11);

    assign uip_val = {23'd0, ext_irq, 3'd0, timer_irq, 3'd0, usip_q};
    assign irq_vec = uie_q & uip_val;

    always_comb begin
        if (irq_vec[8])      irq_code = IRQ_EXT;
        else if (irq_vec[4]) irq_code = IRQ_TIMER;
        else                 irq_code = IRQ_SOFT;
    end

    generate
        if (HAS_COUNTERS) begin : g_counters
            csr_counters u_counters (
                .clk         (clk),
                .rst         (rst),
                .instret_inc (instr_valid & ~trap_taken),
                .addr        (csr_addr),
                .rdata       (cnt_rdata),
                .hit         (cnt_hit)
            );
        end else begin : g_no_counters
            assign cnt_rdata = 32'd0;
            assign cnt_hit   = 1'b0;
        end
    endgenerate

    always_comb begin
        old_val = 32'd0;
        mapped  = 1'b1;
        case (csr_addr)
            CSR_USTATUS: begin
                old_val[USTATUS_UIE]  = uie_bit_q;
                old_val[USTATUS_UPIE] = upie_q;
            end
            CSR_UIE:      old_val = uie_q;
            CSR_UTVEC:    old_val = utvec_q;
            CSR_USCRATCH: old_val = uscratch_q;
            CSR_UEPC:     old_val = uepc_q;
            CSR_UCAUSE:   old_val = ucause_q;
            CSR_UTVAL:    old_val = utval_q;
            CSR_UIP:      old_val = uip_val;
            default: begin
                old_val = cnt_rdata;
                mapped  = cnt_hit;
            end
        endcase
    end

    assign csr_rdata = old_val;
    assign new_val   = csr_modify(op, old_val, src);

    assign csr_illegal = csr & instr_valid & (~mapped | (write_attempt & read_only));

    // Trap decisions are held off during reset so the outputs reflect the reset state.
    assign irq_take   = ~rst & instr_valid & uie_bit_q & (|irq_vec);
    assign exc_take   = ~rst & instr_valid & ~irq_take & (exception | csr_illegal);
    assign trap_taken = irq_take | exc_take;
    assign uret_take  = ~rst & instr_valid & ~trap_taken & uret;
    assign csr_we     = ~rst & instr_valid & csr & ~trap_taken & ~uret & write_attempt;

    assign exc_cause  = csr_illegal ? CAUSE_ILLEGAL : cause;
    assign vec_offset = (irq_take && utvec_q[0]) ? {26'd0, irq_code, 2'b00} : 32'd0;

    assign redirect    = trap_taken | uret_take;
    assign redirect_pc = trap_taken ? ({utvec_q[31:2], 2'b00} + vec_offset) : uepc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            uie_bit_q  <= 1'b0;
            upie_q     <= 1'b0;
            uie_q      <= 32'd0;
            utvec_q    <= {RESET_UTVEC[31:2], 1'b0, RESET_UTVEC[0]};
            uscratch_q <= 32'd0;
            uepc_q     <= 32'd0;
            ucause_q   <= 32'd0;
            utval_q    <= 32'd0;
            usip_q     <= 1'b0;
        end else if (trap_taken) begin
            uepc_q    <= {pc[31:2], 2'b00};
            upie_q    <= uie_bit_q;
            uie_bit_q <= 1'b0;
            if (irq_take) begin
                ucause_q <= {1'b1, 27'd0, irq_code};
                utval_q  <= 32'd0;
            end else begin
                ucause_q <= exc_cause;
                utval_q  <= (exc_cause == CAUSE_ILLEGAL) ? instr : 32'd0;
            end
        end else if (uret_take) begin
            uie_bit_q <= upie_q;
            upie_q    <= 1'b1;
        end else if (csr_we) begin
            case (csr_addr)
                CSR_USTATUS: begin
                    uie_bit_q <= new_val[USTATUS_UIE];
                    upie_q    <= new_val[USTATUS_UPIE];
                end
                CSR_UIE:      uie_q      <= new_val & UIE_MASK;
                CSR_UTVEC:    utvec_q    <= {new_val[31:2], 1'b0, new_val[0]};
                CSR_USCRATCH: uscratch_q <= new_val;
                CSR_UEPC:     uepc_q     <= {new_val[31:2], 2'b00};
                CSR_UCAUSE:   ucause_q   <= new_val;
                CSR_UTVAL:    utval_q    <= new_val;
                CSR_UIP:      usip_q     <= new_val[0];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed self-checking bench for csr_trap_unit: CSR ops, traps, uret, stalls, counters.
module tb_csr_trap_unit;
    import csr_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        csr;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic        exception;
    logic [31:0] cause;
    logic        uret;
    logic        ext_irq;
    logic        timer_irq;
    logic [31:0] csr_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        trap_taken;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [63:0] exp_cycle;
    logic [63:0] exp_instret;

    csr_trap_unit dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .pc          (pc),
        .instr       (instr),
        .csr         (csr),
        .funct3      (funct3),
        .rs1_data    (rs1_data),
        .exception   (exception),
        .cause       (cause),
        .uret        (uret),
        .ext_irq     (ext_irq),
        .timer_irq   (timer_irq),
        .csr_rdata   (csr_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .trap_taken  (trap_taken)
    );

    always #5 clk = ~clk;

    // cycle counts every rising edge out of reset, independent of instr_valid.
    always @(posedge clk) exp_cycle <= rst ? 64'd0 : exp_cycle + 64'd1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] csr_ins(input logic [11:0] a, input logic [4:0] r,
                                            input logic [2:0] f3);
        return {a, r, f3, 5'd1, 7'h73};
    endfunction

    task automatic do_csr(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r,
                          input logic [31:0] rd1, input logic [31:0] p);
        instr_valid = 1'b1;
        csr         = 1'b1;
        funct3      = f3;
        instr       = csr_ins(a, r, f3);
        rs1_data    = rd1;
        pc          = p;
        exception   = 1'b0;
        cause       = 32'd0;
        uret        = 1'b0;
        #2;
    endtask

    task automatic do_plain(input logic [31:0] p, input logic exc, input logic [31:0] cs,
                            input logic ur);
        instr_valid = 1'b1;
        csr         = 1'b0;
        funct3      = 3'b000;
        instr       = 32'h0000_0013;
        rs1_data    = 32'd0;
        pc          = p;
        exception   = exc;
        cause       = cs;
        uret        = ur;
        #2;
    endtask

    task automatic tick(input bit retired);
        if (retired) exp_instret = exp_instret + 64'd1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic read_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        do_csr(F3_CSRRS, a, 5'd0, 32'hFFFF_FFFF, 32'h0000_1000);
        check(tag, csr_rdata, exp);
        tick(1'b1);
    endtask

    initial begin
        rst = 1'b1;
        instr_valid = 1'b0; pc = 32'd0; instr = 32'd0; csr = 1'b0; funct3 = 3'd0;
        rs1_data = 32'd0; exception = 1'b0; cause = 32'd0; uret = 1'b0;
        ext_irq = 1'b0; timer_irq = 1'b0;
        exp_instret = 64'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_redirect", {31'd0, redirect}, 32'd0);
        check("reset_trap", {31'd0, trap_taken}, 32'd0);
        rst = 1'b0;

        read_chk("rst_ustatus", CSR_USTATUS, 32'd0);
        read_chk("rst_utvec", CSR_UTVEC, 32'd0);
        read_chk("rst_uepc", CSR_UEPC, 32'd0);
        read_chk("rst_ucause", CSR_UCAUSE, 32'd0);

        // uscratch read/modify/write, including zero-source RS/RC that must not write
        do_csr(F3_CSRRW, CSR_USCRATCH, 5'd1, 32'hDEAD_BEEF, 32'h10);
        check("rw_old", csr_rdata, 32'd0);
        tick(1'b1);
        do_csr(F3_CSRRS, CSR_USCRATCH, 5'd0, 32'hFFFF_FFFF, 32'h14);
        check("rs_x0_read", csr_rdata, 32'hDEAD_BEEF);
        tick(1'b1);
        do_csr(F3_CSRRC, CSR_USCRATCH, 5'd0, 32'hFFFF_FFFF, 32'h18);
        check("rc_x0_nowrite", csr_rdata, 32'hDEAD_BEEF);
        tick(1'b1);
        do_csr(F3_CSRRCI, CSR_USCRATCH, 5'h0F, 32'hFFFF_FFFF, 32'h1C);
        tick(1'b1);
        read_chk("rci_result", CSR_USCRATCH, 32'hDEAD_BEE0);

        // utvec bit1 is forced to zero
        do_csr(F3_CSRRW, CSR_UTVEC, 5'd1, 32'h0000_0102, 32'h20);
        tick(1'b1);
        read_chk("utvec_mask", CSR_UTVEC, 32'h0000_0100);
        do_csr(F3_CSRRSI, CSR_USTATUS, 5'd1, 32'd0, 32'h24);
        tick(1'b1);
        read_chk("uie_set", CSR_USTATUS, 32'h0000_0001);

        // ecall trap entry and uret return
        do_plain(32'h80, 1'b1, CAUSE_ECALL_U, 1'b0);
        check("ecall_trap", {31'd0, trap_taken}, 32'd1);
        check("ecall_redirect", {31'd0, redirect}, 32'd1);
        check("ecall_pc", redirect_pc, 32'h0000_0100);
        tick(1'b0);
        read_chk("ecall_ucause", CSR_UCAUSE, 32'd8);
        read_chk("ecall_uepc", CSR_UEPC, 32'h80);
        read_chk("ecall_utval", CSR_UTVAL, 32'd0);
        read_chk("ecall_ustatus", CSR_USTATUS, 32'h0000_0010);
        do_plain(32'h84, 1'b0, 32'd0, 1'b1);
        check("uret_redirect", {31'd0, redirect}, 32'd1);
        check("uret_notrap", {31'd0, trap_taken}, 32'd0);
        check("uret_pc", redirect_pc, 32'h80);
        tick(1'b1);
        read_chk("uret_ustatus", CSR_USTATUS, 32'h0000_0011);

        // vectored external interrupt
        do_csr(F3_CSRRW, CSR_UTVEC, 5'd1, 32'h0000_0101, 32'h28);
        tick(1'b1);
        do_csr(F3_CSRRW, CSR_UIE, 5'd1, 32'h0000_0100, 32'h2C);
        tick(1'b1);
        read_chk("uie_val", CSR_UIE, 32'h0000_0100);
        ext_irq = 1'b1;
        do_plain(32'h200, 1'b0, 32'd0, 1'b0);
        check("ext_trap", {31'd0, trap_taken}, 32'd1);
        check("ext_vector", redirect_pc, 32'h0000_0120);
        tick(1'b0);
        ext_irq = 1'b0;
        read_chk("ext_ucause", CSR_UCAUSE, 32'h8000_0008);
        read_chk("ext_uepc", CSR_UEPC, 32'h200);
        read_chk("ext_utval", CSR_UTVAL, 32'd0);
        read_chk("instret_lo", CSR_INSTRET, exp_instret[31:0]);
        read_chk("instret_hi", CSR_INSTRETH, exp_instret[63:32]);

        // write to read-only cycle CSR is illegal
        do_csr(F3_CSRRW, CSR_CYCLE, 5'd1, 32'hFFFF_0000, 32'h300);
        instr = 32'hC000_9073;
        #1;
        check("ro_trap", {31'd0, trap_taken}, 32'd1);
        check("ro_pc", redirect_pc, 32'h0000_0100);
        tick(1'b0);
        read_chk("ro_ucause", CSR_UCAUSE, 32'd2);
        read_chk("ro_utval", CSR_UTVAL, 32'hC000_9073);
        do_csr(F3_CSRRS, CSR_CYCLE, 5'd0, 32'd0, 32'h1000);
        check("cycle_lo", csr_rdata, exp_cycle[31:0]);
        tick(1'b1);
        read_chk("cycle_hi", CSR_CYCLEH, 32'd0);

        // unmapped address
        do_csr(F3_CSRRS, 12'h045, 5'd0, 32'd0, 32'h310);
        check("unmapped_trap", {31'd0, trap_taken}, 32'd1);
        tick(1'b0);
        read_chk("unmapped_utval", CSR_UTVAL, csr_ins(12'h045, 5'd0, F3_CSRRS));

        // stalled cycles hold off a pending interrupt
        do_csr(F3_CSRRSI, CSR_USTATUS, 5'd1, 32'd0, 32'h320);
        tick(1'b1);
        ext_irq = 1'b1;
        do_plain(32'h400, 1'b0, 32'd0, 1'b0);
        instr_valid = 1'b0;
        #1;
        check("stall_redirect", {31'd0, redirect}, 32'd0);
        check("stall_trap", {31'd0, trap_taken}, 32'd0);
        tick(1'b0);
        tick(1'b0);
        do_plain(32'h404, 1'b0, 32'd0, 1'b0);
        check("unstall_trap", {31'd0, trap_taken}, 32'd1);
        check("unstall_pc", redirect_pc, 32'h0000_0120);
        tick(1'b0);
        ext_irq = 1'b0;
        read_chk("unstall_uepc", CSR_UEPC, 32'h404);

        // interrupt priority and interrupt over exception
        do_csr(F3_CSRRSI, CSR_USTATUS, 5'd1, 32'd0, 32'h330);
        tick(1'b1);
        do_csr(F3_CSRRW, CSR_UIE, 5'd1, 32'h0000_0110, 32'h334);
        tick(1'b1);
        ext_irq = 1'b1;
        timer_irq = 1'b1;
        do_plain(32'h500, 1'b1, CAUSE_BREAK, 1'b0);
        check("prio_trap", {31'd0, trap_taken}, 32'd1);
        check("prio_pc", redirect_pc, 32'h0000_0120);
        tick(1'b0);
        ext_irq = 1'b0;
        timer_irq = 1'b0;
        read_chk("prio_ucause", CSR_UCAUSE, 32'h8000_0008);
        read_chk("prio_uepc", CSR_UEPC, 32'h500);

        // uip reflects the level inputs even while interrupts are disabled
        ext_irq = 1'b1;
        read_chk("uip_ext", CSR_UIP, 32'h0000_0100);
        ext_irq = 1'b0;

        // timer interrupt alone uses its own vector slot
        do_csr(F3_CSRRSI, CSR_USTATUS, 5'd1, 32'd0, 32'h340);
        tick(1'b1);
        timer_irq = 1'b1;
        do_plain(32'h600, 1'b0, 32'd0, 1'b0);
        check("timer_pc", redirect_pc, 32'h0000_0110);
        tick(1'b0);
        timer_irq = 1'b0;
        read_chk("timer_ucause", CSR_UCAUSE, 32'h8000_0004);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
